// File: rtl/pd_aux_cal_ctrl_pkg.sv
// Shared state encoding and default tuning for the auxiliary PD offset calibration.
package pd_aux_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESET = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAIL   = 3'd4
  } cal_state_e;

  localparam int NADC_DEF    = 8;
  localparam int NCNTR_DEF   = 8;
  localparam int NWIN_DEF    = 8;
  localparam int TOL_DEF     = 2;
  localparam int MAX_WIN_DEF = 16;

endpackage

// File: rtl/pd_aux_cal_ctrl_if.sv
// Control/status bundle between the calibration sequencer and the auxiliary PD.
interface pd_aux_cal_ctrl_if #(
  parameter int Nadc = 8
);
  logic                   start;
  logic                   abort;
  logic signed [Nadc-1:0] init_offset;
  logic signed [Nadc-1:0] pd_offset;
  logic                   pd_en;
  logic signed [Nadc-1:0] pd_offset_ext;
  logic                   busy;
  logic                   done;
  logic                   fail;

  modport master (
    output start, abort, init_offset, pd_offset,
    input  pd_en, pd_offset_ext, busy, done, fail
  );

  modport slave (
    input  start, abort, init_offset, pd_offset,
    output pd_en, pd_offset_ext, busy, done, fail
  );
endinterface

// File: rtl/pd_aux_cal_ctrl_window.sv
// Signed min/max tracker over one convergence window; min/max/spread/mid include the
// sample presented this cycle so the window can be judged on its last sample.
module pd_offset_window #(
  parameter int Nadc = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   sample,
  input  logic signed [Nadc-1:0] din,
  output logic signed [Nadc-1:0] min,
  output logic signed [Nadc-1:0] max,
  output logic        [Nadc:0]   spread,
  output logic signed [Nadc-1:0] mid
);

  logic signed [Nadc-1:0] min_r;
  logic signed [Nadc-1:0] max_r;
  logic                   valid_r;
  logic signed [Nadc:0]   min_x_s;
  logic signed [Nadc:0]   max_x_s;
  logic signed [Nadc:0]   diff_s;
  logic signed [Nadc:0]   sum_s;

  // Extremes including the current sample; the first sample of a window seeds both
  always_comb begin
    min = min_r;
    max = max_r;
    if (sample) begin
      if (!valid_r || (din < min_r)) begin
        min = din;
      end else begin
        min = min_r;
      end
      if (!valid_r || (din > max_r)) begin
        max = din;
      end else begin
        max = max_r;
      end
    end else begin
      min = min_r;
      max = max_r;
    end
  end

  // One extra bit keeps max-min and min+max free of overflow
  assign min_x_s = {min[Nadc-1], min};
  assign max_x_s = {max[Nadc-1], max};
  assign diff_s  = max_x_s - min_x_s;
  assign sum_s   = max_x_s + min_x_s;
  assign spread  = diff_s;
  assign mid     = sum_s[Nadc:1];

  // Window state register; clr wins over a coincident sample
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid_r <= 1'b0;
      min_r   <= {Nadc{1'b0}};
      max_r   <= {Nadc{1'b0}};
    end else if (sample) begin
      valid_r <= 1'b1;
      min_r   <= min;
      max_r   <= max;
    end
  end

endmodule

// File: rtl/pd_aux_cal_ctrl.sv
// Offset calibration sequencer for the auxiliary phase detector.
// Build option PD_AUX_CAL_TRACK_EN: DONE periodically re-runs calibration from the current offset.
module pd_aux_cal_ctrl
  import pd_aux_cal_pkg::*;
#(
  parameter int Nadc    = NADC_DEF,
  parameter int Ncntr   = NCNTR_DEF,
  parameter int Nwin    = NWIN_DEF,
  parameter int TOL     = TOL_DEF,
  parameter int MAX_WIN = MAX_WIN_DEF
) (
  input logic              clk,
  input logic              rst,
  pd_aux_cal_ctrl_if.slave cal
);

  localparam int WCW = $clog2(MAX_WIN + 1);
  localparam int SCW = $clog2(Nwin + 1);

  cal_state_e             state_r;
  cal_state_e             state_nxt_s;
  logic [Ncntr-1:0]       ep_cnt_r;
  logic [1:0]             epoch_idx_r;
  logic [WCW-1:0]         win_cnt_r;
  logic [SCW-1:0]         smp_cnt_r;
  logic                   pd_en_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   fail_r;
  logic signed [Nadc-1:0] ext_r;
  logic signed [Nadc-1:0] ext_nxt_s;
  logic signed [Nadc-1:0] win_min_s;
  logic signed [Nadc-1:0] win_max_s;
  logic signed [Nadc-1:0] win_mid_s;
  logic        [Nadc:0]   win_spread_s;
  logic                   sample_s;
  logic                   win_end_s;
  logic                   conv_s;
  logic                   max_hit_s;
  logic                   restart_s;
  logic                   win_clr_s;
  logic                   trk_exp_s;

  // Startup epoch and first update epoch are skipped before sampling begins
  assign sample_s  = (state_r == ST_RUN) && (ep_cnt_r == {Ncntr{1'b0}}) && (epoch_idx_r >= 2'd2);
  assign win_end_s = sample_s && (smp_cnt_r == SCW'(Nwin - 1));
  assign conv_s    = (win_max_s >= win_min_s) && (win_spread_s <= (Nadc + 1)'(TOL));
  assign max_hit_s = ((win_cnt_r + 1'b1) == WCW'(MAX_WIN));
  assign win_clr_s = restart_s || (win_end_s && !conv_s);

  pd_offset_window #(
    .Nadc (Nadc)
  ) u_win (
    .clk    (clk),
    .rst    (rst),
    .clr    (win_clr_s),
    .sample (sample_s),
    .din    (cal.pd_offset),
    .min    (win_min_s),
    .max    (win_max_s),
    .spread (win_spread_s),
    .mid    (win_mid_s)
  );

`ifdef PD_AUX_CAL_TRACK_EN
  logic [Ncntr+3:0] trk_tmr_r;

  // Idle timer that only runs while parked in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_tmr_r <= {(Ncntr + 4){1'b0}};
    end else if (state_r == ST_DONE) begin
      trk_tmr_r <= trk_tmr_r + 1'b1;
    end else begin
      trk_tmr_r <= {(Ncntr + 4){1'b0}};
    end
  end

  assign trk_exp_s = (state_r == ST_DONE) && (trk_tmr_r == {(Ncntr + 4){1'b1}});
`else
  assign trk_exp_s = 1'b0;
`endif

  // Next state and next external offset; abort overrides everything but rst
  always_comb begin
    state_nxt_s = state_r;
    ext_nxt_s   = ext_r;
    restart_s   = 1'b0;
    if (cal.abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_FAIL: begin
          if (cal.start) begin
            state_nxt_s = ST_PRESET;
            ext_nxt_s   = cal.init_offset;
            restart_s   = 1'b1;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_PRESET: begin
          state_nxt_s = ST_RUN;
        end
        ST_RUN: begin
          if (win_end_s && conv_s) begin
            state_nxt_s = ST_DONE;
            ext_nxt_s   = win_mid_s;
          end else if (win_end_s && max_hit_s) begin
            state_nxt_s = ST_FAIL;
            ext_nxt_s   = cal.pd_offset;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DONE: begin
          if (cal.start) begin
            state_nxt_s = ST_PRESET;
            ext_nxt_s   = cal.init_offset;
            restart_s   = 1'b1;
          end else if (trk_exp_s) begin
            state_nxt_s = ST_PRESET;
            restart_s   = 1'b1;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      pd_en_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      fail_r  <= 1'b0;
      ext_r   <= {Nadc{1'b0}};
    end else begin
      pd_en_r <= (state_nxt_s == ST_RUN);
      busy_r  <= (state_nxt_s == ST_PRESET) || (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
      fail_r  <= (state_nxt_s == ST_FAIL);
      ext_r   <= ext_nxt_s;
    end
  end

  // Epoch, sample and window bookkeeping; PRESET always precedes RUN, so it clears the epoch counters
  always_ff @(posedge clk) begin
    if (rst) begin
      ep_cnt_r    <= {Ncntr{1'b0}};
      epoch_idx_r <= 2'd0;
      win_cnt_r   <= {WCW{1'b0}};
      smp_cnt_r   <= {SCW{1'b0}};
    end else begin
      if (state_r == ST_PRESET) begin
        ep_cnt_r    <= {Ncntr{1'b0}};
        epoch_idx_r <= 2'd0;
      end else if (state_r == ST_RUN) begin
        ep_cnt_r <= ep_cnt_r + 1'b1;
        if ((ep_cnt_r == {Ncntr{1'b1}}) && (epoch_idx_r != 2'd3)) begin
          epoch_idx_r <= epoch_idx_r + 2'd1;
        end
      end
      if (restart_s) begin
        win_cnt_r <= {WCW{1'b0}};
        smp_cnt_r <= {SCW{1'b0}};
      end else if (win_end_s) begin
        smp_cnt_r <= {SCW{1'b0}};
        if (!conv_s) begin
          win_cnt_r <= win_cnt_r + 1'b1;
        end
      end else if (sample_s) begin
        smp_cnt_r <= smp_cnt_r + 1'b1;
      end
    end
  end

  assign cal.pd_en         = pd_en_r;
  assign cal.busy          = busy_r;
  assign cal.done          = done_r;
  assign cal.fail          = fail_r;
  assign cal.pd_offset_ext = ext_r;

endmodule
